// File: rtl/mux_4_1_rr_sched_pkg.sv
// Shared definitions for the 4:1 round-robin scheduling multiplexer.
// The package holds the source count, the source index width, the payload
// width, the arbiter state encoding and small index helpers. The
// multiplexer and the scheduler top both import it.
package mux_4_1_rr_sched_pkg;

    localparam int N_SRC  = 4;
    localparam int SRC_W  = 2;
    localparam int DATA_W = 4;
    // Holds burst counts up to the largest legal BURST value (8).
    localparam int CNT_W  = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Returns a one-hot vector with the bit for source idx set.
    function automatic logic [N_SRC-1:0] src_onehot(input logic [SRC_W-1:0] idx);
        logic [N_SRC-1:0] vec;
        vec = {N_SRC{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Adds an offset to a source index, modulo N_SRC. The SRC_W-bit result
    // wraps naturally.
    function automatic logic [SRC_W-1:0] src_add(input logic [SRC_W-1:0] idx,
                                                 input logic [SRC_W-1:0] off);
        return idx + off;
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// Combinational 4:1 payload multiplexer.
// Ports:
//   sel            - source select, 2 bits
//   d0, d1, d2, d3 - candidate payloads, W bits each
//   y              - selected payload, W bits
module mux_4_1
    import mux_4_1_rr_sched_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [SRC_W-1:0] sel,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    output logic [W-1:0]     y
);

    // Select one of the four payloads.
    always_comb begin
        y = {W{1'b0}};
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = {W{1'b0}};
        endcase
    end

endmodule

// File: rtl/mux_4_1_rr_sched.sv
// Four-source round-robin scheduler in front of a registered 4:1 multiplexer.
// A source keeps the grant for up to BURST consecutive beats. The grant then
// rotates, starting the search at the source after the last new grant.
// Ports:
//   clk                  - clock; all state updates on the rising edge
//   rst_n                - asynchronous active-low reset
//   in_valid[3:0]        - per-source valid
//   in_data0..in_data3   - per-source 4-bit payloads
//   in_ready[3:0]        - per-source ready, one-hot or zero
//   out_valid            - output register holds a beat
//   out_data[3:0]        - registered payload
//   out_src[1:0]         - index of the source that produced out_data
//   out_ready            - downstream accepts the held beat
module mux_4_1_rr_sched
    import mux_4_1_rr_sched_pkg::*;
#(
    parameter int BURST = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  in_valid,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    output logic [N_SRC-1:0]  in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [SRC_W-1:0]  out_src,
    input  logic              out_ready
);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [SRC_W-1:0]  ptr_r;
    logic [SRC_W-1:0]  ptr_nxt_s;
    logic [SRC_W-1:0]  owner_r;
    logic [SRC_W-1:0]  owner_nxt_s;
    logic [CNT_W-1:0]  burst_cnt_r;
    logic [CNT_W-1:0]  burst_cnt_nxt_s;

    logic              load_en_s;
    logic              grant_vld_s;
    logic              cont_s;
    logic [SRC_W-1:0]  grant_s;
    logic [SRC_W-1:0]  cand_s;
    logic [DATA_W-1:0] mux_y_s;

    // Grant selection: an owner continuation takes priority, otherwise the
    // first valid source searched from ptr.
    always_comb begin
        load_en_s   = !out_valid || out_ready;
        grant_s     = {SRC_W{1'b0}};
        grant_vld_s = 1'b0;
        cont_s      = 1'b0;
        cand_s      = {SRC_W{1'b0}};
        if (load_en_s) begin
            if ((state_r == ARB_LOCK) && in_valid[owner_r]) begin
                grant_s     = owner_r;
                grant_vld_s = 1'b1;
                cont_s      = 1'b1;
            end else begin
                // Walk the offsets from farthest to nearest so that the
                // nearest valid source is the one left in grant_s.
                for (int k = N_SRC - 1; k >= 0; k--) begin
                    cand_s = src_add(ptr_r, SRC_W'(k));
                    if (in_valid[cand_s]) begin
                        grant_s     = cand_s;
                        grant_vld_s = 1'b1;
                    end else begin
                        grant_vld_s = grant_vld_s;
                    end
                end
            end
        end else begin
            grant_vld_s = 1'b0;
        end
    end

    // Arbiter next state: burst counting, pointer rotation and lock release.
    always_comb begin
        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        owner_nxt_s     = owner_r;
        burst_cnt_nxt_s = burst_cnt_r;
        if (grant_vld_s) begin
            if (cont_s) begin
                burst_cnt_nxt_s = burst_cnt_r + CNT_W'(1);
                if (burst_cnt_nxt_s >= CNT_W'(BURST)) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_LOCK;
                end
            end else begin
                ptr_nxt_s       = src_add(grant_s, SRC_W'(1));
                burst_cnt_nxt_s = CNT_W'(1);
                if (BURST > 1) begin
                    state_nxt_s = ARB_LOCK;
                    owner_nxt_s = grant_s;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
        end else if (load_en_s) begin
            // The owner dropped valid or no source is valid, so the lock
            // is released.
            state_nxt_s = ARB_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Ready goes to the granted source only. It is forced low while reset is
    // asserted, because load_en is already high then.
    always_comb begin
        if (grant_vld_s && rst_n) begin
            in_ready = src_onehot(grant_s);
        end else begin
            in_ready = {N_SRC{1'b0}};
        end
    end

    mux_4_1 #(
        .W (DATA_W)
    ) u_mux (
        .sel (grant_s),
        .d0  (in_data0),
        .d1  (in_data1),
        .d2  (in_data2),
        .d3  (in_data3),
        .y   (mux_y_s)
    );

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ARB_IDLE;
            ptr_r       <= {SRC_W{1'b0}};
            owner_r     <= {SRC_W{1'b0}};
            burst_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            owner_r     <= owner_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    // Output register. It loads on an input transfer, empties when the held
    // beat leaves with nothing behind it, and holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= {DATA_W{1'b0}};
            out_src   <= {SRC_W{1'b0}};
        end else if (grant_vld_s) begin
            out_valid <= 1'b1;
            out_data  <= mux_y_s;
            out_src   <= grant_s;
        end else if (load_en_s) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_mux_4_1_rr_sched.sv
module tb_mux_4_1_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_data0, in_data1, in_data2, in_data3;
    logic       out_ready;

    logic [3:0] in_ready_a, in_ready_b;
    logic       out_valid_a, out_valid_b;
    logic [3:0] out_data_a, out_data_b;
    logic [1:0] out_src_a, out_src_b;

    typedef struct packed {
        logic [1:0] src;
        logic [3:0] data;
    } beat_t;

    beat_t sb_q[$];
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    mux_4_1_rr_sched u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready_a),
        .out_valid (out_valid_a),
        .out_data  (out_data_a),
        .out_src   (out_src_a),
        .out_ready (out_ready)
    );

    mux_4_1_rr_sched #(.BURST(1)) u_dut_b1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready_b),
        .out_valid (out_valid_b),
        .out_data  (out_data_b),
        .out_src   (out_src_b),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic [3:0] d);
        beat_t b;
        b.src  = s;
        b.data = d;
        sb_q.push_back(b);
    endtask

    // Compare the beat currently held by the output register with the
    // oldest expected beat.
    task automatic sb_pop(input string tag, input logic v, input logic [1:0] s,
                          input logic [3:0] d);
        beat_t e;
        chk({tag, "_valid"}, {7'd0, v}, 8'd1);
        tests++;
        assert (sb_q.size() > 0) else begin
            fails++;
            $error("FAIL %s_empty: observed beat src %0d data %0h, expected none", tag, s, d);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_src"},  {6'd0, s}, {6'd0, e.src});
            chk({tag, "_data"}, {4'd0, d}, {4'd0, e.data});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data0  = 4'h1;
        in_data1  = 4'h2;
        in_data2  = 4'h3;
        in_data3  = 4'h4;
        out_ready = 1'b1;

        // Reset state, with all sources requesting.
        #1;
        chk("rst_valid", {7'd0, out_valid_a}, 8'd0);
        chk("rst_ready", {4'd0, in_ready_a}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid2", {7'd0, out_valid_a}, 8'd0);
        chk("rst_data", {4'd0, out_data_a}, 8'd0);
        chk("rst_src", {6'd0, out_src_a}, 8'd0);
        chk("rst_ready2", {4'd0, in_ready_a}, 8'd0);
        rst_n = 1'b1;

        // All sources valid, BURST=2: two beats per source in rotation.
        push(2'd0, 4'h1); push(2'd0, 4'h1); push(2'd1, 4'h2); push(2'd1, 4'h2);
        push(2'd2, 4'h3); push(2'd2, 4'h3); push(2'd3, 4'h4); push(2'd3, 4'h4);
        push(2'd0, 4'h1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            sb_pop("rr_all", out_valid_a, out_src_a, out_data_a);
        end
        chk("rr_all_left", 8'(sb_q.size()), 8'd0);

        // Only source 2 valid: one beat every cycle, including across bursts.
        do_reset();
        in_valid = 4'b0100;
        in_data2 = 4'h5;
        for (int i = 0; i < 6; i++) push(2'd2, 4'h5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sb_pop("single", out_valid_a, out_src_a, out_data_a);
        end

        // Back-pressure: the held beat and the grant freeze while out_ready=0.
        do_reset();
        in_valid  = 4'b0100;
        in_data2  = 4'h7;
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_first", {4'd0, out_data_a}, 8'h07);
        in_data2 = 4'h9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", {4'd0, in_ready_a}, 8'd0);
            @(negedge clk);
            chk("stall_valid", {7'd0, out_valid_a}, 8'd1);
            chk("stall_data", {4'd0, out_data_a}, 8'h07);
            chk("stall_src", {6'd0, out_src_a}, 8'd2);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", {4'd0, in_ready_a}, 8'h04);
        @(negedge clk);
        chk("release_valid", {7'd0, out_valid_a}, 8'd1);
        chk("release_data", {4'd0, out_data_a}, 8'h09);
        in_valid = 4'b0000;
        @(negedge clk);
        chk("drain_valid", {7'd0, out_valid_a}, 8'd0);

        // Owner 1 drops after one beat: source 3 wins and the pointer
        // moves to 0, so a later search among 0..2 picks source 0.
        do_reset();
        in_data0 = 4'hC;
        in_data1 = 4'h1;
        in_data2 = 4'hE;
        in_data3 = 4'h3;
        in_valid = 4'b1010;
        push(2'd1, 4'h1); push(2'd3, 4'h3); push(2'd0, 4'hC);
        @(negedge clk);
        sb_pop("drop", out_valid_a, out_src_a, out_data_a);
        in_valid = 4'b1000;
        #1;
        chk("drop_ready", {4'd0, in_ready_a}, 8'h08);
        @(negedge clk);
        sb_pop("drop", out_valid_a, out_src_a, out_data_a);
        in_valid = 4'b0111;
        @(negedge clk);
        sb_pop("drop", out_valid_a, out_src_a, out_data_a);
        in_valid = 4'b0000;

        // Asynchronous reset mid-burst, then restart from source 0.
        do_reset();
        in_data0 = 4'h1;
        in_data1 = 4'h2;
        in_data2 = 4'h3;
        in_data3 = 4'h4;
        in_valid = 4'b1111;
        push(2'd0, 4'h1);
        @(negedge clk);
        sb_pop("mid_rst", out_valid_a, out_src_a, out_data_a);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {7'd0, out_valid_a}, 8'd0);
        chk("async_ready", {4'd0, in_ready_a}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(2'd0, 4'h1); push(2'd0, 4'h1); push(2'd1, 4'h2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sb_pop("post_rst", out_valid_a, out_src_a, out_data_a);
        end

        // BURST=1 instance, sources 0 and 1: strict alternation.
        do_reset();
        in_data0 = 4'hA;
        in_data1 = 4'hB;
        in_valid = 4'b0011;
        push(2'd0, 4'hA); push(2'd1, 4'hB); push(2'd0, 4'hA); push(2'd1, 4'hB);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sb_pop("burst1", out_valid_b, out_src_b, out_data_b);
        end
        in_valid = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_4_1_rr_sched.md
MUX_4_1_RR_SCHED -- requirements
Module: mux_4_1_rr_sched

Interface
REQ-001 The block SHALL have one parameter: BURST, default 2, the maximum number of consecutive beats granted to one source (legal range 1..8).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  4  per-source valid; bit i belongs to source i.
REQ-005 in_data0, in_data1, in_data2, in_data3  input  4 each  per-source payload.
REQ-006 in_ready  output  4  per-source ready; a beat from source i transfers when in_valid[i] && in_ready[i].
REQ-007 out_valid  output  1  output register holds a beat.
REQ-008 out_data  output  4  registered payload.
REQ-009 out_src  output  2  index of the source that produced out_data.
REQ-010 out_ready  input  1  downstream accepts; an output transfer occurs when out_valid && out_ready.

Function
REQ-011 load_en SHALL be defined as !out_valid || out_ready.
REQ-012 in_ready SHALL be one-hot or zero; in_ready[g] SHALL be 1 only when load_en is 1 and g is the current grant; in_ready MAY depend combinationally on in_valid and out_ready.
REQ-013 The FSM SHALL have two states: ARB_IDLE (no owner) and ARB_LOCK (owner locked, burst_cnt beats taken).
REQ-014 In ARB_LOCK with in_valid[owner]=1 and load_en=1, the grant SHALL be the owner.
REQ-015 Otherwise, with load_en=1, the grant SHALL be the first i with in_valid[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); if none is valid, there is no grant and in_ready=0.
REQ-016 In ARB_LOCK with in_valid[owner]=0 and load_en=1, the FSM SHALL go to ARB_IDLE in the same evaluation and arbitrate per REQ-015.
REQ-017 On a new grant (not an owner continuation) to g: ptr SHALL become (g+1) mod 4, burst_cnt SHALL become 1, and the next state SHALL be ARB_LOCK with owner=g if BURST>1, else ARB_IDLE.
REQ-018 On an owner continuation, burst_cnt SHALL increment; when it reaches BURST, the next state SHALL be ARB_IDLE; ptr SHALL NOT change.
REQ-019 With load_en=0, ptr, state, owner, burst_cnt and all outputs SHALL hold, and in_ready SHALL be 0.
REQ-020 A transfer from source g SHALL set out_valid=1, out_data=in_data<g> and out_src=g on the next edge (latency 1 cycle).
REQ-021 An output transfer with no input transfer in the same cycle SHALL clear out_valid; simultaneous output and input transfers SHALL keep out_valid=1 with the new beat (throughput 1 beat/cycle).
REQ-022 out_data and out_src SHALL be stable while out_valid && !out_ready.
REQ-023 Fairness: a continuously valid source SHALL be granted within 3*BURST+1 accepted beats.

Reset
REQ-024 With rst_n=0, the block SHALL force out_valid=0, out_data=0, out_src=0, ptr=0, owner=0, burst_cnt=0 and state=ARB_IDLE immediately, independent of clk.
REQ-025 Reset asserted mid-burst SHALL drop the held beat and the lock; after release, arbitration SHALL restart from source 0.
REQ-026 in_ready SHALL be 0 while rst_n=0.

Structure
REQ-027 A shared package SHALL hold N_SRC=4, SRC_W=2 and the state enum {ARB_IDLE, ARB_LOCK}.
REQ-028 Payload selection SHALL instantiate the existing mux_4_1 once, with the grant index driving sel; the arbiter and output register SHALL be local logic.

Verification
REQ-029 All four valid with data {a,b,c,d}, out_ready=1, BURST=2: out_src sequence SHALL be 0,0,1,1,2,2,3,3,0 and out_data SHALL be a,a,b,b,c,c,d,d,a.
REQ-030 Only source 2 valid with data 5, BURST=2: one beat per cycle SHALL appear with out_src=2 and out_data=5, with no idle cycles.
REQ-031 out_ready=0 for 3 cycles with out_valid=1, out_data=7: out_data/out_src SHALL hold and in_ready SHALL be 0; the first cycle with out_ready=1 SHALL transfer 7 and load the next beat.
REQ-032 Owner 1 drops in_valid after 1 beat while source 3 is valid: the next grant SHALL be 3, and ptr SHALL become 0.
REQ-033 Assert rst_n=0 between clock edges mid-burst: out_valid SHALL go to 0 immediately; after release with all sources valid, the first out_src SHALL be 0.
REQ-034 BURST=1, sources 0 and 1 valid: out_src SHALL alternate 0,1,0,1.
